// File: rtl/counter_run_scheduler_pkg.sv
// Shared types and helpers for the counter run scheduler.
// Optional build macro CNT_SCHED_PRIO0_EN is consumed by rr_arbiter and counter_run_scheduler.
package counter_run_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    localparam int LEN_BUS_MAX = 1024;

    // Extract run-length slice idx (width bits each) from a zero-extended packed bus.
    function automatic logic [63:0] len_slice(input logic [LEN_BUS_MAX-1:0] bus,
                                              input int unsigned idx,
                                              input int unsigned width);
        logic [LEN_BUS_MAX-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[63:0] & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/counter_run_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping.
// With CNT_SCHED_PRIO0_EN defined, requester 0 wins outright and is skipped by the rotation.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int   c;
    logic elig;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        c         = 0;
        elig      = 1'b0;
`ifdef CNT_SCHED_PRIO0_EN
        if (req[0]) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end
`endif
        for (int i = 1; i <= NUM_REQ; i++) begin
            c    = (int'(last) + i) % NUM_REQ;
            elig = req[IDX_W'(c)];
`ifdef CNT_SCHED_PRIO0_EN
            if (c == 0) elig = 1'b0;
`endif
            if (!any && elig) begin
                grant[IDX_W'(c)] = 1'b1;
                grant_idx        = IDX_W'(c);
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_run_scheduler.sv
// Time-shares one external up-counter between NUM_REQ requesters, one run at a time.
// Build option CNT_SCHED_PRIO0_EN: requester 0 gets strict priority and never moves the pointer.
module counter_run_scheduler
    import counter_run_scheduler_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     abort,
    output logic                     cnt_load,
    output logic [WIDTH-1:0]         cnt_load_value,
    output logic                     cnt_enable,
    input  logic [WIDTH-1:0]         cnt_count,
    input  logic                     cnt_overflow,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     done,
    output logic [IDX_W-1:0]         done_id,
    output logic                     done_err
);

    sched_state_e         state_q, state_d;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     id_q;
    logic [WIDTH-1:0]     len_q;
    logic                 err_q, err_d;
    logic                 capture;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .last      (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
`ifdef CNT_SCHED_PRIO0_EN
            if (state_q == DONE && id_q != '0) ptr_q <= id_q;
`else
            if (state_q == DONE) ptr_q <= id_q;
`endif
        end
    end

    // Run parameters are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            len_q <= WIDTH'(len_slice(LEN_BUS_MAX'(req_len), 32'(arb_idx), 32'(WIDTH)));
            id_q  <= arb_idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        capture    = 1'b0;
        req_ready  = '0;
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    capture   = 1'b1;
                    err_d     = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_enable = (cnt_count != len_q) && !abort;
                // abort beats overflow beats a length match
                if (abort || cnt_overflow) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_count == len_q) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_load_value = '0;
    assign busy           = (state_q != IDLE);
    assign grant_id       = busy ? id_q : '0;
    assign done           = (state_q == DONE);
    assign done_id        = done ? id_q : '0;
    assign done_err       = done && err_q;

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Directed bench for counter_run_scheduler with a behavioural counter and a run scoreboard.
// Honours CNT_SCHED_PRIO0_EN when the design is built with it.
module tb_counter_run_scheduler;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_len = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     abort = 1'b0;
    logic                     cnt_load;
    logic [WIDTH-1:0]         cnt_load_value;
    logic                     cnt_enable;
    logic [WIDTH-1:0]         cnt_count = '0;
    logic                     cnt_overflow = 1'b0;
    logic                     busy;
    logic [IDX_W-1:0]         grant_id;
    logic                     done;
    logic [IDX_W-1:0]         done_id;
    logic                     done_err;

    counter_run_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_len        (req_len),
        .req_ready      (req_ready),
        .abort          (abort),
        .cnt_load       (cnt_load),
        .cnt_load_value (cnt_load_value),
        .cnt_enable     (cnt_enable),
        .cnt_count      (cnt_count),
        .cnt_overflow   (cnt_overflow),
        .busy           (busy),
        .grant_id       (grant_id),
        .done           (done),
        .done_id        (done_id),
        .done_err       (done_err)
    );

    always #5 clk = ~clk;

    int             cyc = 0;
    int             en_cnt = 0;
    logic [WIDTH-1:0] max_count = 8'd255;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural up-counter with a one-cycle wrap flag.
    always @(posedge clk) begin
        cnt_overflow <= 1'b0;
        if (cnt_load) begin
            cnt_count <= '0;
            en_cnt    <= 0;
        end else if (cnt_enable) begin
            en_cnt <= en_cnt + 1;
            if (cnt_count == max_count) begin
                cnt_count    <= '0;
                cnt_overflow <= 1'b1;
            end else begin
                cnt_count <= cnt_count + 8'd1;
            end
        end
    end

    typedef struct {
        int id;
        int err;
        int done_cyc;
        int en;
    } exp_t;

    exp_t             sbq[$];
    logic [3:0]       acc_q[$];
    int               lens[NUM_REQ];
    int               ovr_lat = -1;
    int               ovr_en = -1;
    int               exp_err = 0;
    int               ptr_model = NUM_REQ - 1;
    int               load_cyc = -100;
    int               last_t = 0;
    int               n_acc = 0;
    int               checks = 0;
    int               failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] v);
        int c;
`ifdef CNT_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (ptr_model + i) % NUM_REQ;
`ifdef CNT_SCHED_PRIO0_EN
            if (c != 0 && v[2'(c)]) return c;
`else
            if (v[2'(c)]) return c;
`endif
        end
        return -1;
    endfunction

    task automatic set_lens();
        for (int i = 0; i < NUM_REQ; i++) req_len[i*WIDTH +: WIDTH] = 8'(lens[i]);
    endtask

    // Check one cycle (inputs already applied), update the scoreboard, advance one clock.
    task automatic tick();
        bit         idle;
        int         g;
        logic [3:0] exp_ready;
        exp_t       e;
        #1;
        idle      = (sbq.size() == 0);
        g         = -1;
        exp_ready = '0;
        if (idle && reset_n && req_valid != '0) begin
            g         = pick(req_valid);
            exp_ready = 4'(1 << g);
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(!idle));
        chk("grant_id", 32'(grant_id), idle ? 0 : sbq[0].id);
        chk("cnt_load", 32'(cnt_load), 32'(cyc == load_cyc));
        if (cnt_load) chk("cnt_load_value", 32'(cnt_load_value), 0);
        if (req_ready != '0) acc_q.push_back(req_ready);
        if (!idle) begin
            chk("done", 32'(done), 32'(cyc == sbq[0].done_cyc));
            if (done || cyc >= sbq[0].done_cyc) begin
                e = sbq.pop_front();
                if (done) begin
                    chk("done_id", 32'(done_id), e.id);
                    chk("done_err", 32'(done_err), e.err);
                    chk("enable_cycles", en_cnt, e.en);
                end
`ifdef CNT_SCHED_PRIO0_EN
                if (e.id != 0) ptr_model = e.id;
`else
                ptr_model = e.id;
`endif
            end
        end else begin
            chk("done_idle", 32'(done), 0);
        end
        if (g >= 0) begin
            e.id       = g;
            e.err      = exp_err;
            e.done_cyc = cyc + 3 + ((ovr_lat >= 0) ? ovr_lat : lens[2'(g)]);
            e.en       = (ovr_en >= 0) ? ovr_en : lens[2'(g)];
            sbq.push_back(e);
            n_acc++;
            last_t   = cyc;
            load_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        abort     = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_done_err", 32'(done_err), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_cnt_load", 32'(cnt_load), 0);
        chk("rst_cnt_enable", 32'(cnt_enable), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        sbq.delete();
        load_cyc  = -100;
        ptr_model = NUM_REQ - 1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int start;
        int n;
        logic [3:0] ord;
        for (int i = 0; i < NUM_REQ; i++) lens[i] = 1;
        set_lens();
        #2;
        do_reset();

        // 1: single run of 3 counts, abort while idle must be ignored
        lens[0] = 3;
        set_lens();
        req_valid = 4'b0001;
        abort     = 1'b1;
        tick();
        req_valid = '0;
        abort     = 1'b0;
        drain();

        // 2: all four requesting continuously, len 1 each
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) lens[i] = 1;
        set_lens();
        acc_q.delete();
        start     = n_acc;
        req_valid = 4'b1111;
        n = 0;
        while (n_acc < start + 5 && n < 100) begin
            tick();
            n++;
        end
        req_valid = '0;
        drain();
        chk("rr_accepts", acc_q.size(), 5);
        for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
`ifdef CNT_SCHED_PRIO0_EN
            ord = 4'b0001;
`else
            ord = 4'(1 << (i % 4));
`endif
            chk("rr_order", 32'(acc_q[i]), 32'(ord));
        end

        // 3: zero-length run on requester 2
        lens[2] = 0;
        set_lens();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        drain();

        // 4: len 10 aborted in the 4th RUN cycle
        lens[0] = 10;
        set_lens();
        ovr_lat = 3;
        ovr_en  = 3;
        exp_err = 1;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        n = 0;
        while (cyc < last_t + 5 && n < 20) begin
            tick();
            n++;
        end
        abort = 1'b1;
        #1;
        chk("abort_enable", 32'(cnt_enable), 0);
        tick();
        abort = 1'b0;
        drain();

        // 5: run longer than a MAX_COUNT=5 counter ends by overflow, then a normal run
        max_count = 8'd5;
        lens[1]   = 8;
        set_lens();
        ovr_lat = 6;
        ovr_en  = 7;
        exp_err = 1;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        drain();
        ovr_lat   = -1;
        ovr_en    = -1;
        exp_err   = 0;
        max_count = 8'd255;
        lens[1]   = 2;
        set_lens();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        drain();

        // 6: reset in the middle of a run, then arbitration restarts at requester 0
        lens[3] = 10;
        set_lens();
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < NUM_REQ; i++) lens[i] = 1;
        set_lens();
        acc_q.delete();
        req_valid = 4'b1111;
        tick();
        req_valid = '0;
        drain();
        chk("first_after_reset", acc_q.size() > 0 ? 32'(acc_q[0]) : 32'hffff, 32'h1);

        // requester 0 versus the rotation after requester 1 has been served
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        drain();
        acc_q.delete();
        req_valid = 4'b0101;
        tick();
        req_valid = '0;
        drain();
`ifdef CNT_SCHED_PRIO0_EN
        chk("prio_pick", acc_q.size() > 0 ? 32'(acc_q[0]) : 32'hffff, 32'h1);
`else
        chk("prio_pick", acc_q.size() > 0 ? 32'(acc_q[0]) : 32'hffff, 32'h4);
`endif

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
